// File: rtl/pe_arb_pkg.sv
// Shared types and constants for the four-requester arbiter.
//   arb_state_t  : IDLE / GRANT / RELEASE controller states
//   NREQ, ID_W   : requester count and encoded-index width
//   id_to_onehot : converts an encoded owner index to a one-hot grant vector
package pe_arb_pkg;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    RELEASE = 2'b10
  } arb_state_t;

  function automatic logic [NREQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    return NREQ'(1) << id;
  endfunction

endpackage

// File: rtl/pe_prio_enc4.sv
// Four-input priority encoder with a programmable starting index.
// Search order is start, start-1, start-2, start-3 (modulo 4); the first set
// request bit in that order wins. start=3 gives plain highest-index-wins.
// Ports:
//   req   in  [3:0]  request vector
//   start in  [1:0]  index searched first
//   id    out [1:0]  winning index (0 when no request)
//   valid out        any request present
module pe_prio_enc4
  import pe_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] start,
  output logic [ID_W-1:0] id,
  output logic            valid
);

  // Rotate req so the requester at 'start' lands on bit 3; a fixed
  // highest-bit search on the rotated vector then yields the rotating order.
  logic [NREQ-1:0] w_rot;
  logic [ID_W-1:0] w_pos;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_rot
      localparam logic [ID_W-1:0] OFF = ID_W'(gi + 1);
      assign w_rot[gi] = req[start + OFF];
    end
  endgenerate

  always_comb begin
    w_pos = 2'd0;
    if (w_rot[3])      w_pos = 2'd3;
    else if (w_rot[2]) w_pos = 2'd2;
    else if (w_rot[1]) w_pos = 2'd1;
  end

  // Undo the rotation: rotated bit p corresponds to requester start+p+1.
  assign id    = valid ? (start + w_pos + 2'd1) : 2'd0;
  assign valid = |req;

endmodule

// File: rtl/pe_arbiter4.sv
// Four-requester arbiter for a single shared downstream port.
// The winner is registered, keeps the grant until it signals done, drops its
// request, or holds for MAX_HOLD cycles; a dead RELEASE cycle then follows
// before the next arbitration.
// Build option: define PE_ARB_ROUND_ROBIN_EN to rotate priority starting
// below the previous owner; otherwise priority is fixed (3 > 2 > 1 > 0).
// Ports:
//   clk       in        rising-edge clock
//   rst_n     in        asynchronous active-low reset
//   req       in  [3:0] level-sensitive request vector
//   done      in        owner releases the grant (only honoured in GRANT)
//   gnt       out [3:0] registered one-hot grant
//   gnt_id    out [1:0] registered owner index, 0 when no owner
//   gnt_valid out       a grant is held
//   timeout   out       one-cycle pulse after a forced release
module pe_arbiter4
  import pe_arb_pkg::*;
#(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            gnt_valid,
  output logic            timeout
);

  arb_state_t       r_state,    w_state_nxt;
  logic [NREQ-1:0]  r_gnt,      w_gnt_nxt;
  logic [ID_W-1:0]  r_gnt_id,   w_gnt_id_nxt;
  logic             r_valid,    w_valid_nxt;
  logic             r_timeout,  w_timeout_nxt;
  logic [CNT_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic [ID_W-1:0]  r_last_id,  w_last_id_nxt;

  logic [ID_W-1:0]  w_start;
  logic [ID_W-1:0]  w_enc_id;
  logic             w_enc_valid;
  logic             w_rel_done;
  logic             w_rel_drop;
  logic             w_rel_max;
  logic             w_release;

`ifdef PE_ARB_ROUND_ROBIN_EN
  // Previous owner is searched last; 2-bit wrap gives the modulo-4 order.
  assign w_start = r_last_id - 2'd1;
`else
  assign w_start = 2'd3;
`endif

  pe_prio_enc4 u_enc (
    .req   (req),
    .start (w_start),
    .id    (w_enc_id),
    .valid (w_enc_valid)
  );

  assign w_rel_done = done;
  assign w_rel_drop = ~req[r_gnt_id];
  assign w_rel_max  = (r_hold_cnt == CNT_W'(MAX_HOLD));
  assign w_release  = w_rel_done | w_rel_drop | w_rel_max;

  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_gnt_id_nxt   = r_gnt_id;
    w_valid_nxt    = r_valid;
    w_timeout_nxt  = 1'b0;
    w_hold_cnt_nxt = r_hold_cnt;
    w_last_id_nxt  = r_last_id;

    case (r_state)
      IDLE: begin
        if (w_enc_valid) begin
          w_state_nxt    = GRANT;
          w_gnt_nxt      = id_to_onehot(w_enc_id);
          w_gnt_id_nxt   = w_enc_id;
          w_valid_nxt    = 1'b1;
          w_hold_cnt_nxt = CNT_W'(1);
        end
      end

      GRANT: begin
        if (w_release) begin
          w_state_nxt    = RELEASE;
          w_gnt_nxt      = '0;
          w_gnt_id_nxt   = '0;
          w_valid_nxt    = 1'b0;
          w_hold_cnt_nxt = '0;
          w_last_id_nxt  = r_gnt_id;
          // A voluntary release on the same edge suppresses the timeout flag.
          w_timeout_nxt  = w_rel_max & ~w_rel_done & ~w_rel_drop;
        end else if (r_hold_cnt != CNT_W'(MAX_HOLD)) begin
          w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
        end
      end

      RELEASE: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt    = IDLE;
        w_gnt_nxt      = '0;
        w_gnt_id_nxt   = '0;
        w_valid_nxt    = 1'b0;
        w_hold_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_gnt_id   <= '0;
      r_valid    <= 1'b0;
      r_timeout  <= 1'b0;
      r_hold_cnt <= '0;
      r_last_id  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_gnt_id   <= w_gnt_id_nxt;
      r_valid    <= w_valid_nxt;
      r_timeout  <= w_timeout_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_last_id  <= w_last_id_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_valid;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_pe_arbiter4.sv
module tb_pe_arbiter4;

  localparam int MAX_HOLD = 3;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int n_tests;
  int n_fail;

  // Reference model: who owns the port, for how long, and whether we are in
  // the post-release gap.
  int m_owner;   // -1 when nobody owns the port
  int m_hold;
  int m_last;
  bit m_dead;    // the cycle right after a release
  bit m_tmo;

  pe_arbiter4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic m_reset();
    m_owner = -1;
    m_hold  = 0;
    m_last  = 0;
    m_dead  = 1'b0;
    m_tmo   = 1'b0;
  endtask

  function automatic int m_winner(input logic [3:0] r, input int last);
    int s;
    int idx;
`ifdef PE_ARB_ROUND_ROBIN_EN
    s = (last + 3) % 4;
`else
    s = 3 + (last * 0);
`endif
    for (int k = 0; k < 4; k++) begin
      idx = (s - k + 4) % 4;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic m_step(input logic [3:0] r, input logic d);
    int  w;
    bit  rel_max;
    bit  rel_vol;
    m_tmo = 1'b0;
    if (m_dead) begin
      m_dead = 1'b0;
    end else if (m_owner < 0) begin
      w = m_winner(r, m_last);
      if (w >= 0) begin
        m_owner = w;
        m_hold  = 1;
      end
    end else begin
      rel_vol = d || !r[m_owner];
      rel_max = (m_hold == MAX_HOLD);
      if (rel_vol || rel_max) begin
        m_tmo   = rel_max && !rel_vol;
        m_last  = m_owner;
        m_owner = -1;
        m_dead  = 1'b1;
      end else if (m_hold < MAX_HOLD) begin
        m_hold = m_hold + 1;
      end
    end
  endtask

  function automatic logic [7:0] exp_out();
    logic [3:0] g;
    logic [1:0] id;
    g  = 4'b0000;
    id = 2'b00;
    if (m_owner >= 0) begin
      g  = 4'(1 << m_owner);
      id = 2'(m_owner);
    end
    return {g, id, (m_owner >= 0), m_tmo};
  endfunction

  // Drive one cycle of stimulus, advance the model, sample 1 time unit later.
  task automatic step(input string tag, input logic [3:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    m_step(r, d);
    #1;
    $display("[TB] %s req=%b done=%b gnt=%b id=%0d valid=%b timeout=%b",
             tag, r, d, gnt, gnt_id, gnt_valid, timeout);
  endtask

  task automatic settle();
    for (int k = 0; k < 3; k++) step("settle", 4'b0000, 1'b0);
  endtask

  task automatic test_reset();
    req   = 4'b1111;
    done  = 1'b0;
    rst_n = 1'b0;
    m_reset();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if ({gnt, gnt_id, gnt_valid, timeout} !== 8'h00) begin
        n_fail++;
        $display("[TB] FAIL reset_hold: got %b expected %b", {gnt, gnt_id, gnt_valid, timeout}, 8'h00);
      end
    end
    rst_n = 1'b1;
    step("reset_exit", 4'b1111, 1'b0);
    n_tests++;
    if ({gnt, gnt_id, gnt_valid} !== {4'b1000, 2'd3, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL reset_first_grant: got gnt=%b id=%0d valid=%b expected gnt=1000 id=3 valid=1",
               gnt, gnt_id, gnt_valid);
    end
    // Asynchronous reset while a grant is held clears outputs without a clock.
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    n_tests++;
    if ({gnt, gnt_id, gnt_valid, timeout} !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL reset_async: got %b expected %b", {gnt, gnt_id, gnt_valid, timeout}, 8'h00);
    end
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_fixed_priority();
    logic [3:0] rq [0:4];
    logic [0:4] dn;
    logic [3:0] eg [0:4];
    rq = '{4'b0011, 4'b1011, 4'b1011, 4'b1011, 4'b1011};
    dn = 5'b00100;
    eg = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b1000};
    settle();
    for (int k = 0; k < 5; k++) begin
      step("fixed", rq[k], dn[k]);
      n_tests++;
      if ({gnt, gnt_id, gnt_valid, timeout} !== exp_out() || gnt !== eg[k]) begin
        n_fail++;
        $display("[TB] FAIL fixed_prio[%0d]: got gnt=%b out=%b expected gnt=%b out=%b",
                 k, gnt, {gnt, gnt_id, gnt_valid, timeout}, eg[k], exp_out());
      end
    end
  endtask

  task automatic test_owner_drop();
    logic [3:0] rq [0:3];
    logic [3:0] eg [0:3];
    rq = '{4'b0100, 4'b0100, 4'b0000, 4'b0000};
    eg = '{4'b0100, 4'b0100, 4'b0000, 4'b0000};
    settle();
    for (int k = 0; k < 4; k++) begin
      step("drop", rq[k], 1'b0);
      n_tests++;
      if ({gnt, gnt_id, gnt_valid, timeout} !== exp_out() || gnt !== eg[k] || timeout !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL owner_drop[%0d]: got gnt=%b timeout=%b expected gnt=%b timeout=0",
                 k, gnt, timeout, eg[k]);
      end
    end
  endtask

  task automatic test_timeout();
    logic [3:0] eg [0:6];
    logic [0:6] et;
    eg = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001};
    et = 7'b0001000;
    settle();
    for (int k = 0; k < 7; k++) begin
      step("timeout", 4'b0001, 1'b0);
      n_tests++;
      if ({gnt, gnt_id, gnt_valid, timeout} !== exp_out() || gnt !== eg[k] || timeout !== et[k]) begin
        n_fail++;
        $display("[TB] FAIL timeout[%0d]: got gnt=%b timeout=%b expected gnt=%b timeout=%b",
                 k, gnt, timeout, eg[k], et[k]);
      end
    end
  endtask

  task automatic test_done_vs_timeout();
    // Picks up from test_timeout: owner 0 granted, hold count 2.
    step("done_tmo", 4'b0001, 1'b0);
    step("done_tmo", 4'b0001, 1'b1);
    n_tests++;
    if ({gnt, gnt_id, gnt_valid, timeout} !== exp_out() || timeout !== 1'b0 || gnt !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL done_vs_timeout: got gnt=%b timeout=%b expected gnt=0000 timeout=0",
               gnt, timeout);
    end
  endtask

  task automatic test_round_robin();
    int seq [0:4];
`ifdef PE_ARB_ROUND_ROBIN_EN
    seq = '{3, 2, 1, 0, 3};
`else
    seq = '{3, 3, 3, 3, 3};
`endif
    rst_n = 1'b0;
    m_reset();
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step("rr", 4'b1111, 1'b0);
      n_tests++;
      if ({gnt, gnt_id, gnt_valid, timeout} !== exp_out() || gnt_valid !== 1'b1 || int'(gnt_id) != seq[k]) begin
        n_fail++;
        $display("[TB] FAIL round_robin[%0d]: got id=%0d valid=%b expected id=%0d valid=1",
                 k, gnt_id, gnt_valid, seq[k]);
      end
      step("rr", 4'b1111, 1'b1);
      step("rr", 4'b1111, 1'b0);
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic       d;
    r = 4'b0000;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 2) == 0) r = 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 3) == 0);
      if (k == 150) begin
        rst_n = 1'b0;
        m_reset();
        #2;
        rst_n = 1'b1;
      end
      step("random", r, d);
      n_tests++;
      if ({gnt, gnt_id, gnt_valid, timeout} !== exp_out()) begin
        n_fail++;
        $display("[TB] FAIL random[%0d]: got %b expected %b (gnt,id,valid,timeout)",
                 k, {gnt, gnt_id, gnt_valid, timeout}, exp_out());
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    req     = 4'b0000;
    done    = 1'b0;
    m_reset();
    test_reset();
    test_fixed_priority();
    test_owner_drop();
    test_timeout();
    test_done_vs_timeout();
    test_round_robin();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
